dram_line_xfer: RTL and testbench
=================================

# dram_line_xfer

Line-transfer engine between the MA-stage data RAM's 128-bit line port and an external memory bus. It executes one multi-line command at a time: writeback (data RAM to external) or fill (external to data RAM). It drives the data RAM's `*_all` port and stalls the CPU while it owns the RAM. A host/debug controller issues commands; the external side uses valid/ready handshakes.

## Interface
- `DWIDTH`, default 11: data RAM word-address width; line address is `DWIDTH-2` bits.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `cmd_start`  in  1  command strobe, sampled only in IDLE
- `cmd_dir`  in  1  0 = writeback (RAM→ext), 1 = fill (ext→RAM)
- `cmd_line_adr`  in  DWIDTH-2  first line address
- `cmd_line_cnt`  in  DWIDTH-1  number of lines, 0..2^(DWIDTH-2)
- `cmd_busy`  out  1  command in progress
- `cmd_done`  out  1  one-cycle completion pulse
- `cmd_err`  out  1  one-cycle reject pulse; present only with macro, see Configuration
- `cpu_stall`  out  1  CPU must hold MA stage; equals `cmd_busy`
- `ram_radr_all`  out  DWIDTH-2  RAM line read address
- `ram_ren_all`  out  1  RAM line read enable
- `ram_rdata_all`  in  128  RAM line read data, valid one cycle after `ram_ren_all`
- `ram_wadr_all`  out  DWIDTH-2  RAM line write address
- `ram_wdata_all`  out  128  RAM line write data
- `ram_wen_all`  out  1  RAM full-line write enable
- `ext_wvalid` / `ext_wready`  out/in  1  writeback handshake
- `ext_wadr`  out  DWIDTH-2  writeback line address
- `ext_wdata`  out  128  writeback line data
- `ext_rvalid` / `ext_rready`  in/out  1  fill handshake
- `ext_rdata`  in  128  fill line data

## Operation
- States: IDLE, RD_REQ, RD_CAP, WB_SEND, FL_RECV, FL_WRITE, DONE.
- IDLE + `cmd_start`:
  - Latch address into `cur_adr` and count into `remain`.
  - `cmd_line_cnt`==0 → DONE.
  - Otherwise go to RD_REQ (`cmd_dir`=0) or FL_RECV (`cmd_dir`=1).
- RD_REQ: `ram_ren_all`=1, `ram_radr_all`=`cur_adr`. Go to RD_CAP.
- RD_CAP: latch `ram_rdata_all` into 128-bit `line_buf`. Go to WB_SEND.
- WB_SEND: `ext_wvalid`=1, `ext_wdata`=`line_buf`, `ext_wadr`=`cur_adr`. Hold until `ext_wready`.
  - On handshake: `cur_adr`+1, `remain`-1.
  - Go to RD_REQ if `remain`>1, else DONE.
- FL_RECV: `ext_rready`=1. On `ext_rvalid`, latch `ext_rdata` into `line_buf` and go to FL_WRITE.
- FL_WRITE: `ram_wen_all`=1, `ram_wadr_all`=`cur_adr`, `ram_wdata_all`=`line_buf`.
  - `cur_adr`+1, `remain`-1.
  - Go to FL_RECV if `remain`>1, else DONE.
- DONE: `cmd_done`=1 for one cycle, then IDLE.
- `cmd_busy` = (state != IDLE). `cmd_start` while busy is ignored; no queueing.
- `cur_adr` increment wraps modulo 2^(DWIDTH-2), e.g. line 511 → 0 for DWIDTH=11.
- `ram_ren_all` and `ram_wen_all` are never asserted together.
- `ext_wvalid` stays asserted with stable data/address until accepted.
- Reset, including mid-command: all outputs 0, state IDLE, `line_buf`/`cur_adr`/`remain` cleared. The partial transfer is abandoned; no done pulse.

## Timing
- Outputs are decoded from registered state/data; no combinational input→output paths except `cpu_stall`=`cmd_busy`.
- `cmd_start` sampled at edge 0:
  - `cmd_busy`/`cpu_stall` high from cycle 1.
  - `cmd_done` is in the last busy cycle; IDLE is the cycle after.
- Writeback, per line: RD_REQ, RD_CAP, then WB_SEND for ≥1 cycle.
  - Minimum 3 cycles/line. N lines with `ext_wready` tied high: done in cycle 3N+1.
- Fill, per line: FL_RECV for ≥1 cycle, then FL_WRITE.
  - Minimum 2 cycles/line. N lines with `ext_rvalid` tied high: done in cycle 2N+1.
- Zero-count command: `cmd_done` in cycle 1, no RAM or external activity.

## Configuration
- `DRAM_XFER_BOUND_CHK_EN` defined:
  - IDLE rejects any command with `cmd_line_adr` + `cmd_line_cnt` > 2^(DWIDTH-2).
  - Reject = `cmd_err` pulse in cycle 1; `cmd_busy`, `cmd_done` and the state stay unchanged.
- Not defined: `cmd_err` tied 0, no check, address wraps.

## Test plan
- Reset mid-command: assert `rst_n`=0 during WB_SEND → all outputs 0 immediately; after release, state IDLE and no `cmd_done`.
- Writeback, adr=5, cnt=3, `ext_wready`=1: `ram_ren_all` at lines 5,6,7; `ext_wdata` equals preloaded RAM lines; `cmd_done` in cycle 10.
- Writeback backpressure: `ext_wready` low for 4 cycles on line 2 → `ext_wvalid`, `ext_wdata` and `ext_wadr` stable throughout; no extra RAM reads.
- Fill, adr=510, cnt=4, DWIDTH=11, macro off: RAM writes land at lines 510,511,0,1 with the matching `ext_rdata` words; `ext_rready` low in FL_WRITE cycles.
- Zero count and busy strobe: cnt=0 → `cmd_done` in cycle 1. A second `cmd_start` during a 2-line fill is ignored; exactly 2 lines are written.
- Macro on: adr=510, cnt=4 → `cmd_err` pulse, `cmd_busy` stays 0; adr=508, cnt=4 → accepted.

Source files
------------

// File: rtl/dram_line_xfer.sv
// Purpose : moves whole 128-bit lines between the MA-stage data RAM line port
//           and an external memory bus, one multi-line command at a time.
//           Writeback copies RAM to external memory; fill copies external
//           memory into the RAM.
// Latency : cmd_busy rises the cycle after cmd_start. A writeback line takes
//           at least 3 cycles and a fill line at least 2. cmd_done is the
//           last busy cycle.
// Backpr. : ext_wready low holds WB_SEND with address and data frozen.
//           ext_rvalid low holds FL_RECV. cmd_start is ignored while busy.
//
// Optional feature: define DRAM_XFER_BOUND_CHK_EN to reject commands whose
// line range runs past the top of the RAM. The reject is a one-cycle cmd_err
// pulse and the engine stays idle. When the macro is not defined, cmd_err is
// tied low and the line address wraps to line 0.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   cmd_*               command strobe, direction, first line and line count,
//                       plus the busy, done and err status outputs
//   cpu_stall           holds the CPU MA stage while the engine owns the RAM
//   ram_*_all           full-line read and write port of the data RAM.
//                       Read data arrives one cycle after ram_ren_all.
//   ext_w*              writeback channel (valid/ready, line address + data)
//   ext_r*              fill channel (valid/ready, line data)

module dram_line_xfer #(
    parameter int DWIDTH = 11
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                cmd_start,
    input  logic                cmd_dir,
    input  logic [DWIDTH-3:0]   cmd_line_adr,
    input  logic [DWIDTH-2:0]   cmd_line_cnt,
    output logic                cmd_busy,
    output logic                cmd_done,
    output logic                cmd_err,
    output logic                cpu_stall,

    output logic [DWIDTH-3:0]   ram_radr_all,
    output logic                ram_ren_all,
    input  logic [127:0]        ram_rdata_all,
    output logic [DWIDTH-3:0]   ram_wadr_all,
    output logic [127:0]        ram_wdata_all,
    output logic                ram_wen_all,

    output logic                ext_wvalid,
    input  logic                ext_wready,
    output logic [DWIDTH-3:0]   ext_wadr,
    output logic [127:0]        ext_wdata,

    input  logic                ext_rvalid,
    output logic                ext_rready,
    input  logic [127:0]        ext_rdata
);

    localparam int LW = DWIDTH - 2;   // line address width
    localparam int CW = DWIDTH - 1;   // line count width; holds 0..2^LW

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_CAP   = 3'd2,
        WB_SEND  = 3'd3,
        FL_RECV  = 3'd4,
        FL_WRITE = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   cur_adr_q, cur_adr_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic [127:0]    line_buf_q, line_buf_d;

    // Address and count both advance as each line completes. The last line
    // is the one that sees remain_q == 1.
    logic [LW-1:0]   cur_adr_inc;
    logic [CW-1:0]   remain_dec;
    logic            last_line;

    assign cur_adr_inc = cur_adr_q + LW'(1);   // wraps modulo 2^LW
    assign remain_dec  = remain_q - CW'(1);
    assign last_line   = !(remain_q > CW'(1));

`ifdef DRAM_XFER_BOUND_CHK_EN
    // The sum can reach 2^LW-1 + 2^CW-1, so it needs DWIDTH bits to avoid
    // wrapping back under the limit.
    localparam int NLINES = 1 << LW;

    logic              err_q, err_d;
    logic [DWIDTH-1:0] bound_sum;
    logic              bound_bad;

    assign bound_sum = DWIDTH'(cmd_line_adr) + DWIDTH'(cmd_line_cnt);
    assign bound_bad = bound_sum > DWIDTH'(NLINES);
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_adr_q  <= '0;
            remain_q   <= '0;
            line_buf_q <= '0;
`ifdef DRAM_XFER_BOUND_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_adr_q  <= cur_adr_d;
            remain_q   <= remain_d;
            line_buf_q <= line_buf_d;
`ifdef DRAM_XFER_BOUND_CHK_EN
            err_q      <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_adr_d  = cur_adr_q;
        remain_d   = remain_q;
        line_buf_d = line_buf_q;
`ifdef DRAM_XFER_BOUND_CHK_EN
        err_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
`ifdef DRAM_XFER_BOUND_CHK_EN
                    if (bound_bad) begin
                        // Rejected: only the error pulse is produced, nothing is latched.
                        err_d = 1'b1;
                    end else
`endif
                    begin
                        cur_adr_d = cmd_line_adr;
                        remain_d  = cmd_line_cnt;
                        if (cmd_line_cnt == '0) begin
                            state_d = DONE;
                        end else if (cmd_dir) begin
                            state_d = FL_RECV;
                        end else begin
                            state_d = RD_REQ;
                        end
                    end
                end
            end

            RD_REQ: begin
                state_d = RD_CAP;
            end

            RD_CAP: begin
                // Read data belongs to the RD_REQ issued in the previous cycle.
                line_buf_d = ram_rdata_all;
                state_d    = WB_SEND;
            end

            WB_SEND: begin
                if (ext_wready) begin
                    cur_adr_d = cur_adr_inc;
                    remain_d  = remain_dec;
                    state_d   = last_line ? DONE : RD_REQ;
                end
            end

            FL_RECV: begin
                if (ext_rvalid) begin
                    line_buf_d = ext_rdata;
                    state_d    = FL_WRITE;
                end
            end

            FL_WRITE: begin
                cur_adr_d = cur_adr_inc;
                remain_d  = remain_dec;
                state_d   = last_line ? FL_RECV_OR_DONE(last_line) : FL_RECV;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Selects the state that follows a completed fill line.
    function automatic state_t FL_RECV_OR_DONE(input logic is_last);
        return is_last ? DONE : FL_RECV;
    endfunction

    // ------------------------------------------------------------------
    // Outputs, decoded from the registered state only. Address and data
    // buses are driven to zero outside the states that qualify them, which
    // keeps idle and reset values clean.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_busy      = 1'b0;
        cmd_done      = 1'b0;
        ram_ren_all   = 1'b0;
        ram_radr_all  = '0;
        ram_wen_all   = 1'b0;
        ram_wadr_all  = '0;
        ram_wdata_all = '0;
        ext_wvalid    = 1'b0;
        ext_wadr      = '0;
        ext_wdata     = '0;
        ext_rready    = 1'b0;

        cmd_busy = (state_q != IDLE);

        case (state_q)
            RD_REQ: begin
                ram_ren_all  = 1'b1;
                ram_radr_all = cur_adr_q;
            end
            WB_SEND: begin
                ext_wvalid = 1'b1;
                ext_wadr   = cur_adr_q;
                ext_wdata  = line_buf_q;
            end
            FL_RECV: begin
                ext_rready = 1'b1;
            end
            FL_WRITE: begin
                ram_wen_all   = 1'b1;
                ram_wadr_all  = cur_adr_q;
                ram_wdata_all = line_buf_q;
            end
            DONE: begin
                cmd_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cpu_stall = cmd_busy;

`ifdef DRAM_XFER_BOUND_CHK_EN
    assign cmd_err = err_q;
`else
    assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_line_xfer.sv
module tb_dram_line_xfer;
    localparam int DW = 11;
    localparam int LW = DW - 2;
    localparam int CW = DW - 1;
    localparam int NL = 1 << LW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            cmd_start;
    logic            cmd_dir;
    logic [LW-1:0]   cmd_line_adr;
    logic [CW-1:0]   cmd_line_cnt;
    logic            cmd_busy, cmd_done, cmd_err, cpu_stall;
    logic [LW-1:0]   ram_radr_all, ram_wadr_all, ext_wadr;
    logic            ram_ren_all, ram_wen_all;
    logic [127:0]    ram_rdata_all, ram_wdata_all, ext_wdata, ext_rdata;
    logic            ext_wvalid, ext_wready, ext_rvalid, ext_rready;

    int tests = 0;
    int fails = 0;

    dram_line_xfer #(.DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_dir(cmd_dir),
        .cmd_line_adr(cmd_line_adr), .cmd_line_cnt(cmd_line_cnt),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .cpu_stall(cpu_stall),
        .ram_radr_all(ram_radr_all), .ram_ren_all(ram_ren_all), .ram_rdata_all(ram_rdata_all),
        .ram_wadr_all(ram_wadr_all), .ram_wdata_all(ram_wdata_all), .ram_wen_all(ram_wen_all),
        .ext_wvalid(ext_wvalid), .ext_wready(ext_wready), .ext_wadr(ext_wadr), .ext_wdata(ext_wdata),
        .ext_rvalid(ext_rvalid), .ext_rready(ext_rready), .ext_rdata(ext_rdata)
    );

    // Preloaded RAM contents and external fill stream, both distinct per line.
    function automatic logic [127:0] mem_pat(input int i);
        return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
                32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)};
    endfunction

    function automatic logic [127:0] fill_pat(input int k);
        return {32'hE000_0000 + 32'(k), 32'hF000_0000 + 32'(k),
                32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)};
    endfunction

    function automatic logic bound_bad(input logic [LW-1:0] adr, input logic [CW-1:0] cnt);
`ifdef DRAM_XFER_BOUND_CHK_EN
        return (int'(adr) + int'(cnt)) > NL;
`else
        return 1'b0;
`endif
    endfunction

    // RAM model with one-cycle read latency, plus the external fill source.
    logic [127:0] mem [NL];
    logic         preload = 1'b1;
    logic [31:0]  fill_idx = 32'd0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NL; i++) mem[i] <= mem_pat(i);
        end else begin
            if (ram_wen_all) mem[ram_wadr_all] <= ram_wdata_all;
            if (ram_ren_all) ram_rdata_all <= mem[ram_radr_all];
        end
        if (ext_rvalid && ext_rready) fill_idx <= fill_idx + 32'd1;
    end

    assign ext_rdata = fill_pat(int'(fill_idx));

    // Activity logs, sampled on the falling edge.
    logic [LW-1:0] rd_log[$];
    logic [LW-1:0] wr_adr_log[$];
    logic [LW-1:0] wb_adr_log[$];
    logic [127:0]  wr_dat_log[$];
    logic [127:0]  wb_dat_log[$];
    logic          log_clr = 1'b0;
    int            excl_bad = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (log_clr) begin
            rd_log.delete();
            wr_adr_log.delete();
            wr_dat_log.delete();
            wb_adr_log.delete();
            wb_dat_log.delete();
            excl_bad <= 0;
            done_cnt <= 0;
        end else begin
            if (ram_ren_all) rd_log.push_back(ram_radr_all);
            if (ram_wen_all) begin
                wr_adr_log.push_back(ram_wadr_all);
                wr_dat_log.push_back(ram_wdata_all);
            end
            if (ext_wvalid && ext_wready) begin
                wb_adr_log.push_back(ext_wadr);
                wb_dat_log.push_back(ext_wdata);
            end
            if ((ram_ren_all && ram_wen_all) || (ram_wen_all && ext_rready)) excl_bad <= excl_bad + 1;
            if (cmd_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1. cmd_start is sampled at the next edge (edge 0),
    // and the task returns at posedge+1 of cycle 1.
    task automatic start_cmd(input logic dir, input logic [LW-1:0] adr, input logic [CW-1:0] cnt);
        cmd_dir = dir;
        cmd_line_adr = adr;
        cmd_line_cnt = cnt;
        cmd_start = 1'b1;
        log_clr = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        log_clr = 1'b0;
    endtask

    task automatic run_cmd(input logic dir, input logic [LW-1:0] adr, input logic [CW-1:0] cnt,
                           input int budget, output int done_cyc, output logic busy1,
                           output logic err1, output logic err2, output logic idle_after,
                           output int stall_bad);
        start_cmd(dir, adr, cnt);
        done_cyc = -1;
        busy1 = cmd_busy;
        err1 = cmd_err;
        err2 = 1'b0;
        idle_after = 1'b0;
        stall_bad = 0;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (cpu_stall !== cmd_busy) stall_bad++;
            if (c == 2) err2 = cmd_err;
            if (done_cyc >= 0) begin
                idle_after = !cmd_busy;
                break;
            end
            if (cmd_done) done_cyc = c;
        end
    endtask

    typedef struct {
        logic          dir;
        logic [LW-1:0] adr;
        logic [CW-1:0] cnt;
        int            exp_done;
    } vec_t;

    localparam int NV = 8;

    initial begin
        vec_t vecs [NV];
        int   done_cyc, stall_bad, line, held, unstable, base;
        logic busy1, err1, err2, idle_after, seen;
        logic [LW-1:0]  cap_a;
        logic [127:0]   cap_d;

        // Writebacks run before the fills so that the preloaded lines are
        // still intact when they are read.
        vecs[0] = '{1'b0, 9'd5,   10'd3,   10};
        vecs[1] = '{1'b0, 9'd0,   10'd512, 1537};
        vecs[2] = '{1'b0, 9'd511, 10'd2,   7};
        vecs[3] = '{1'b0, 9'd77,  10'd0,   1};
        vecs[4] = '{1'b1, 9'd300, 10'd0,   1};
        vecs[5] = '{1'b1, 9'd510, 10'd4,   9};
        vecs[6] = '{1'b1, 9'd0,   10'd1,   3};
        vecs[7] = '{1'b1, 9'd508, 10'd4,   9};

        rst_n = 1'b0;
        cmd_start = 1'b0;
        cmd_dir = 1'b0;
        cmd_line_adr = '0;
        cmd_line_cnt = '0;
        ext_wready = 1'b1;
        ext_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        chk("reset_ctrl", {cmd_busy, cmd_done, cmd_err, cpu_stall, ram_ren_all, ram_wen_all,
                           ext_wvalid, ext_rready}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            logic          e;
            int            n, psize, other, first;
            logic [LW-1:0] ea, aa;
            logic [127:0]  ed, ad;
            e = bound_bad(vecs[v].adr, vecs[v].cnt);
            n = e ? 0 : int'(vecs[v].cnt);
            base = int'(fill_idx);
            run_cmd(vecs[v].dir, vecs[v].adr, vecs[v].cnt, e ? 12 : 2000,
                    done_cyc, busy1, err1, err2, idle_after, stall_bad);
            chk($sformatf("v%0d_busy_c1", v), busy1, !e);
            chk($sformatf("v%0d_err_c1", v), err1, e);
            chk($sformatf("v%0d_err_c2", v), err2, 1'b0);
            chk($sformatf("v%0d_done_cycle", v), done_cyc, e ? -1 : vecs[v].exp_done);
            if (!e) chk($sformatf("v%0d_idle_after", v), idle_after, 1'b1);
            chk($sformatf("v%0d_stall_eq_busy", v), stall_bad, 0);
            chk($sformatf("v%0d_exclusive", v), excl_bad, 0);
            psize = vecs[v].dir ? wr_adr_log.size() : wb_adr_log.size();
            other = vecs[v].dir ? rd_log.size() + wb_adr_log.size() : wr_adr_log.size();
            chk($sformatf("v%0d_nlines", v), psize, n);
            chk($sformatf("v%0d_other_side", v), other, 0);
            if (!vecs[v].dir) chk($sformatf("v%0d_nreads", v), rd_log.size(), n);
            // Locate the first line that disagrees (or line 0) and compare it.
            first = 0;
            for (int i = 0; i < n && i < psize; i++) begin
                ea = LW'(int'(vecs[v].adr) + i);
                ed = vecs[v].dir ? fill_pat(base + i) : mem_pat(int'(ea));
                aa = vecs[v].dir ? wr_adr_log[i] : wb_adr_log[i];
                ad = vecs[v].dir ? wr_dat_log[i] : wb_dat_log[i];
                if (aa !== ea || ad !== ed || (!vecs[v].dir && rd_log.size() > i && rd_log[i] !== ea)) begin
                    first = i;
                    break;
                end
            end
            if (psize > first && n > first) begin
                ea = LW'(int'(vecs[v].adr) + first);
                ed = vecs[v].dir ? fill_pat(base + first) : mem_pat(int'(ea));
                chk($sformatf("v%0d_line%0d_adr", v, first),
                    vecs[v].dir ? wr_adr_log[first] : wb_adr_log[first], ea);
                chk($sformatf("v%0d_line%0d_data", v, first),
                    vecs[v].dir ? wr_dat_log[first] : wb_dat_log[first], ed);
                if (!vecs[v].dir && rd_log.size() > first)
                    chk($sformatf("v%0d_line%0d_radr", v, first), rd_log[first], ea);
            end
        end

        // Writeback with ext_wready held low for 4 cycles on the second line.
        ext_wready = 1'b1;
        start_cmd(1'b0, 9'd20, 10'd3);
        line = 0; held = 0; unstable = 0; done_cyc = -1;
        cap_a = '0; cap_d = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (cmd_done) begin done_cyc = c; break; end
            if (ext_wvalid) begin
                if (line == 1 && held < 4) begin
                    if (held == 0) begin cap_a = ext_wadr; cap_d = ext_wdata; end
                    else if (ext_wadr !== cap_a || ext_wdata !== cap_d) unstable++;
                    ext_wready = 1'b0;
                    held++;
                end else begin
                    if (line == 1 && (ext_wadr !== cap_a || ext_wdata !== cap_d)) unstable++;
                    ext_wready = 1'b1;
                    line++;
                end
            end
        end
        ext_wready = 1'b1;
        chk("bp_done_cycle", done_cyc, 14);
        chk("bp_held_cycles", held, 4);
        chk("bp_stable", unstable, 0);
        chk("bp_nreads", rd_log.size(), 3);
        chk("bp_nsent", wb_adr_log.size(), 3);
        if (wb_adr_log.size() == 3) begin
            chk("bp_line1_adr", wb_adr_log[1], 9'd21);
            chk("bp_line1_data", wb_dat_log[1], mem_pat(21));
            chk("bp_line2_data", wb_dat_log[2], mem_pat(22));
        end
        @(posedge clk); #1;

        // Two-line fill with ext_rvalid late and a second strobe while busy.
        ext_rvalid = 1'b0;
        base = int'(fill_idx);
        start_cmd(1'b1, 9'd100, 10'd2);
        done_cyc = -1;
        idle_after = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (done_cyc >= 0) begin idle_after = !cmd_busy; break; end
            if (cmd_done) done_cyc = c;
            if (c == 2) begin
                cmd_start = 1'b1; cmd_dir = 1'b0; cmd_line_adr = 9'd0; cmd_line_cnt = 10'd5;
            end else begin
                cmd_start = 1'b0;
            end
            if (c == 3) ext_rvalid = 1'b1;
        end
        chk("strobe_done_cycle", done_cyc, 7);
        chk("strobe_idle_after", idle_after, 1'b1);
        chk("strobe_nwrites", wr_adr_log.size(), 2);
        chk("strobe_nreads", rd_log.size(), 0);
        chk("strobe_exclusive", excl_bad, 0);
        if (wr_adr_log.size() == 2) begin
            chk("strobe_line0_adr", wr_adr_log[0], 9'd100);
            chk("strobe_line1_adr", wr_adr_log[1], 9'd101);
            chk("strobe_line0_data", wr_dat_log[0], fill_pat(base));
            chk("strobe_line1_data", wr_dat_log[1], fill_pat(base + 1));
        end

        // Reset asserted while a writeback sits in WB_SEND.
        ext_wready = 1'b0;
        start_cmd(1'b0, 9'd40, 10'd2);
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (ext_wvalid) begin seen = 1'b1; break; end
        end
        chk("rst_reached_wb_send", seen, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl_zero", {cmd_busy, cmd_done, cmd_err, cpu_stall, ram_ren_all, ram_wen_all,
                              ext_wvalid, ext_rready}, 8'h00);
        chk("rst_adr_zero", ram_radr_all | ram_wadr_all | ext_wadr, 9'd0);
        chk("rst_data_zero", ram_wdata_all | ext_wdata, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ext_wready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_idle_after", cmd_busy, 1'b0);
        chk("rst_no_done", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
